// File: rtl/key_cmd_pkg.sv
// rtl/key_cmd_pkg.sv - shared types and constants for the key command sequencer
// Contents: sequencer state enum, HHMMSS digit index constants, digit range
// limits, and a helper that maps a digit index to its nibble position.
package key_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ENT_TIME  = 3'd1,
    ENT_ALARM = 3'd2,
    WAIT_CR_T = 3'd3,
    WAIT_CR_A = 3'd4
  } state_t;

  localparam logic [2:0] IDX_H10  = 3'd0;
  localparam logic [2:0] IDX_H1   = 3'd1;
  localparam logic [2:0] IDX_M10  = 3'd2;
  localparam logic [2:0] IDX_M1   = 3'd3;
  localparam logic [2:0] IDX_S10  = 3'd4;
  localparam logic [2:0] IDX_S1   = 3'd5;
  localparam logic [2:0] IDX_DONE = 3'd6;

  localparam logic [3:0] H10_MAX      = 4'd2;
  localparam logic [3:0] H1_MAX_AT_20 = 4'd3;

  // H10 sits in the top nibble, S1 in the bottom one.
  function automatic logic [4:0] nib_lsb(input logic [2:0] idx);
    case (idx)
      IDX_H10: nib_lsb = 5'd20;
      IDX_H1:  nib_lsb = 5'd16;
      IDX_M10: nib_lsb = 5'd12;
      IDX_M1:  nib_lsb = 5'd8;
      IDX_S10: nib_lsb = 5'd4;
      default: nib_lsb = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// rtl/bcd_entry_reg.sv - six-nibble HHMMSS entry register with range checking
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clr        clear all digits and the index
//   wr_en      a digit key is offered this cycle
//   digit      offered digit value (0..9)
//   in0to5     offered digit is in 0..5
//   digits     BCD {H10,H1,M10,M1,S10,S1}
//   idx        digits accepted so far (0..6)
//   accept     the offered digit is valid for the current position
//   done       accept of the sixth digit
module bcd_entry_reg
  import key_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [3:0]  digit,
  input  logic        in0to5,
  output logic [23:0] digits,
  output logic [2:0]  idx,
  output logic        accept,
  output logic        done
);

  logic range_ok;

  always_comb begin
    range_ok = 1'b0;
    case (idx)
      IDX_H10:          range_ok = (digit <= H10_MAX);
      // 20..23 is the only decade where H1 is limited.
      IDX_H1:           range_ok = (digits[23:20] != H10_MAX) || (digit <= H1_MAX_AT_20);
      IDX_M10, IDX_S10: range_ok = in0to5;
      IDX_M1, IDX_S1:   range_ok = 1'b1;
      default:          range_ok = 1'b0;
    endcase
  end

  assign accept = wr_en && range_ok;
  assign done   = accept && (idx == IDX_S1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digits <= '0;
      idx    <= '0;
    end else if (accept) begin
      digits[nib_lsb(idx) +: 4] <= digit;
      idx                       <= idx + 3'd1;
    end
  end

endmodule

// File: rtl/key_cmd_seq.sv
// rtl/key_cmd_seq.sv - key command sequencer between key decoder and clock datapath
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   charData          raw ASCII character, low nibble is the digit value
//   det_*             one-cycle decoded key strobes
//   run_en            clock counting enabled
//   alarm_en          alarm armed
//   disp_hold         display frozen
//   led_sel           selected LED
//   entry_active      an entry dialog is open
//   entry_idx         digits accepted so far
//   set_digits        BCD {H10,H1,M10,M1,S10,S1}
//   set_time_pulse    one-cycle time load strobe
//   set_alarm_pulse   one-cycle alarm load strobe
module key_cmd_seq
  import key_cmd_pkg::*;
#(
  parameter int NUM_LED       = 4,
  parameter int LED_SEL_W     = 2,
  parameter int ENTRY_TIMEOUT = 0,
  parameter int TO_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           charData,
  input  logic                 det_esc,
  input  logic                 det_num,
  input  logic                 det_num0to5,
  input  logic                 det_cr,
  input  logic                 det_atSign,
  input  logic                 det_A,
  input  logic                 det_L,
  input  logic                 det_N,
  input  logic                 det_S,
  output logic                 run_en,
  output logic                 alarm_en,
  output logic                 disp_hold,
  output logic [LED_SEL_W-1:0] led_sel,
  output logic                 entry_active,
  output logic [2:0]           entry_idx,
  output logic [23:0]          set_digits,
  output logic                 set_time_pulse,
  output logic                 set_alarm_pulse
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ENTRY_TIMEOUT > 0 ? ENTRY_TIMEOUT - 1 : 0);
  localparam logic [LED_SEL_W-1:0] LED_LAST = LED_SEL_W'(NUM_LED - 1);

  state_t state, state_nxt;
  logic run_nxt, alarm_nxt, hold_nxt, active_nxt, tp_nxt, ap_nxt;
  logic [LED_SEL_W-1:0] led_nxt;
  logic [TO_W-1:0] to_cnt;
  logic clr, wr_en, accept, done, timeout, in_entry, any_key;
  logic k_esc, k_cr, k_num, k_at, k_s, k_a, k_l, k_n;
  logic unused_char;

  // The decoder only raises det_num for '0'..'9', so the high nibble carries nothing.
  assign unused_char = ^charData[7:4];

  // One key acts per cycle: esc > cr > num > atSign > S > A > L > N.
  assign k_esc = det_esc;
  assign k_cr  = det_cr & ~det_esc;
  assign k_num = det_num & ~det_esc & ~det_cr;
  assign k_at  = det_atSign & ~(det_esc | det_cr | det_num);
  assign k_s   = det_S & ~(det_esc | det_cr | det_num | det_atSign);
  assign k_a   = det_A & ~(det_esc | det_cr | det_num | det_atSign | det_S);
  assign k_l   = det_L & ~(det_esc | det_cr | det_num | det_atSign | det_S | det_A);
  assign k_n   = det_N & ~(det_esc | det_cr | det_num | det_atSign | det_S | det_A | det_L);

  assign any_key  = det_esc | det_cr | det_num | det_num0to5 | det_atSign |
                    det_A | det_L | det_N | det_S;
  assign in_entry = (state != IDLE);
  assign wr_en    = k_num && ((state == ENT_TIME) || (state == ENT_ALARM));

  // Fires on the last idle cycle of the window so the abort lands exactly
  // ENTRY_TIMEOUT quiet cycles after the most recent key.
  assign timeout = (ENTRY_TIMEOUT > 0) && in_entry && !any_key && (to_cnt == TO_LAST);

  bcd_entry_reg u_entry (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .wr_en  (wr_en),
    .digit  (charData[3:0]),
    .in0to5 (det_num0to5),
    .digits (set_digits),
    .idx    (entry_idx),
    .accept (accept),
    .done   (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      run_en          <= 1'b0;
      alarm_en        <= 1'b0;
      disp_hold       <= 1'b0;
      led_sel         <= '0;
      entry_active    <= 1'b0;
      set_time_pulse  <= 1'b0;
      set_alarm_pulse <= 1'b0;
    end else begin
      state           <= state_nxt;
      run_en          <= run_nxt;
      alarm_en        <= alarm_nxt;
      disp_hold       <= hold_nxt;
      led_sel         <= led_nxt;
      entry_active    <= active_nxt;
      set_time_pulse  <= tp_nxt;
      set_alarm_pulse <= ap_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !in_entry || any_key || (ENTRY_TIMEOUT == 0)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    run_nxt    = run_en;
    alarm_nxt  = alarm_en;
    hold_nxt   = disp_hold;
    led_nxt    = led_sel;
    active_nxt = entry_active;
    tp_nxt     = 1'b0;
    ap_nxt     = 1'b0;
    clr        = 1'b0;
    case (state)
      IDLE: begin
        // Also drops entry_active in the cycle after a load pulse.
        active_nxt = 1'b0;
        if (k_esc) begin
          state_nxt  = ENT_TIME;
          clr        = 1'b1;
          active_nxt = 1'b1;
        end else if (k_cr) begin
          run_nxt = 1'b0;
        end else if (k_at) begin
          state_nxt  = ENT_ALARM;
          clr        = 1'b1;
          active_nxt = 1'b1;
        end else if (k_s) begin
          run_nxt = 1'b1;
        end else if (k_a) begin
          alarm_nxt = ~alarm_en;
        end else if (k_l) begin
          hold_nxt = ~disp_hold;
        end else if (k_n) begin
          led_nxt = (led_sel == LED_LAST) ? '0 : led_sel + LED_SEL_W'(1);
        end
      end
      ENT_TIME, ENT_ALARM: begin
        if (k_esc || timeout) begin
          state_nxt  = IDLE;
          active_nxt = 1'b0;
        end else if (done) begin
          state_nxt = (state == ENT_TIME) ? WAIT_CR_T : WAIT_CR_A;
        end
      end
      WAIT_CR_T, WAIT_CR_A: begin
        if (k_esc || timeout) begin
          state_nxt  = IDLE;
          active_nxt = 1'b0;
        end else if (k_cr) begin
          // set_digits is untouched until the next entry, so it is stable with the pulse.
          tp_nxt    = (state == WAIT_CR_T);
          ap_nxt    = (state == WAIT_CR_A);
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        active_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_cmd_seq.sv
// tb/tb_key_cmd_seq.sv - self-checking bench for key_cmd_seq
module tb_key_cmd_seq;

  localparam logic [7:0] ESC = 8'h1b;
  localparam logic [7:0] CR  = 8'h0d;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  charData;
  logic        det_esc, det_num, det_num0to5, det_cr, det_atSign, det_A, det_L, det_N, det_S;
  logic        run_en, alarm_en, disp_hold, entry_active, set_time_pulse, set_alarm_pulse;
  logic [1:0]  led_sel;
  logic [2:0]  entry_idx;
  logic [23:0] set_digits;

  int errors = 0;
  int checks = 0;
  logic [24:0] exp_q[$];   // {is_alarm, digits}
  logic prev_pulse = 1'b0;

  always #5 clk = ~clk;

  key_cmd_seq #(
    .NUM_LED       (4),
    .LED_SEL_W     (2),
    .ENTRY_TIMEOUT (8),
    .TO_W          (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .charData        (charData),
    .det_esc         (det_esc),
    .det_num         (det_num),
    .det_num0to5     (det_num0to5),
    .det_cr          (det_cr),
    .det_atSign      (det_atSign),
    .det_A           (det_A),
    .det_L           (det_L),
    .det_N           (det_N),
    .det_S           (det_S),
    .run_en          (run_en),
    .alarm_en        (alarm_en),
    .disp_hold       (disp_hold),
    .led_sel         (led_sel),
    .entry_active    (entry_active),
    .entry_idx       (entry_idx),
    .set_digits      (set_digits),
    .set_time_pulse  (set_time_pulse),
    .set_alarm_pulse (set_alarm_pulse)
  );

  // Pulse scoreboard: every load pulse must match the oldest expected entry.
  always @(negedge clk) begin
    logic [24:0] e;
    if (set_time_pulse || set_alarm_pulse) begin
      checks++;
      if (set_time_pulse && set_alarm_pulse) begin
        errors++; $display("FAIL pulse_both: time=%0b alarm=%0b, required one only", set_time_pulse, set_alarm_pulse);
      end else if (prev_pulse) begin
        errors++; $display("FAIL pulse_consecutive: pulse high two cycles running, required single cycle");
      end else if (exp_q.size() == 0) begin
        errors++; $display("FAIL pulse_unexpected: alarm=%0b digits=%h, required no pulse", set_alarm_pulse, set_digits);
      end else begin
        e = exp_q.pop_front();
        if ({set_alarm_pulse, set_digits} !== e) begin
          errors++; $display("FAIL pulse_data: got alarm=%0b digits=%h, required alarm=%0b digits=%h",
                             set_alarm_pulse, set_digits, e[24], e[23:0]);
        end
      end
    end
    prev_pulse = set_time_pulse || set_alarm_pulse;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // s = {esc, num, num0to5, cr, atSign, A, L, N, S}
  task drive_raw(input logic [8:0] s, input logic [7:0] ch);
    @(negedge clk);
    {det_esc, det_num, det_num0to5, det_cr, det_atSign, det_A, det_L, det_N, det_S} = s;
    charData = ch;
    @(negedge clk);
    {det_esc, det_num, det_num0to5, det_cr, det_atSign, det_A, det_L, det_N, det_S} = '0;
    charData = 8'h00;
  endtask

  task press(input logic [7:0] ch);
    logic [8:0] s;
    s = '0;
    case (ch)
      8'h1b: s[8] = 1'b1;
      8'h0d: s[5] = 1'b1;
      8'h40: s[4] = 1'b1;
      8'h41: s[3] = 1'b1;
      8'h4c: s[2] = 1'b1;
      8'h4e: s[1] = 1'b1;
      8'h53: s[0] = 1'b1;
      default: begin
        if (ch >= 8'h30 && ch <= 8'h39) begin
          s[7] = 1'b1;
          if (ch <= 8'h35) s[6] = 1'b1;
        end
      end
    endcase
    drive_raw(s, ch);
  endtask

  task press_str(input string str);
    for (int i = 0; i < str.len(); i++) press(str[i]);
  endtask

  task drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s: %0d expected pulse(s) never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task test_reset;
    rst = 1'b1;
    charData = 8'h00;
    {det_esc, det_num, det_num0to5, det_cr, det_atSign, det_A, det_L, det_N, det_S} = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({run_en, alarm_en, disp_hold, led_sel, entry_active} !== 6'b0) begin
      errors++; $display("FAIL reset_modes: got %b, required 000000", {run_en, alarm_en, disp_hold, led_sel, entry_active});
    end
    checks++;
    if ({entry_idx, set_digits, set_time_pulse, set_alarm_pulse} !== 29'b0) begin
      errors++; $display("FAIL reset_entry: idx=%0d digits=%h pulses=%b%b, required all 0",
                         entry_idx, set_digits, set_time_pulse, set_alarm_pulse);
    end
  endtask

  task test_modes;
    press_str("SANN");
    checks++; if (run_en !== 1'b1)   begin errors++; $display("FAIL modes_run: got %0b, required 1", run_en); end
    checks++; if (alarm_en !== 1'b1) begin errors++; $display("FAIL modes_alarm: got %0b, required 1", alarm_en); end
    checks++; if (led_sel !== 2'd2)  begin errors++; $display("FAIL modes_led: got %0d, required 2", led_sel); end
    press_str("NN");
    checks++; if (led_sel !== 2'd0)  begin errors++; $display("FAIL modes_led_wrap: got %0d, required 0", led_sel); end
    press("L");
    checks++; if (disp_hold !== 1'b1) begin errors++; $display("FAIL modes_hold: got %0b, required 1", disp_hold); end
    press(CR);
    press("A");
    checks++; if ({run_en, alarm_en} !== 2'b00) begin errors++; $display("FAIL modes_cr_a: got %b, required 00", {run_en, alarm_en}); end
    // S and A together: S wins, alarm untouched
    drive_raw(9'b000001001, 8'h53);
    checks++; if ({run_en, alarm_en} !== 2'b10) begin errors++; $display("FAIL modes_prio: got %b, required 10", {run_en, alarm_en}); end
    // esc and cr together: esc wins and opens time entry
    drive_raw(9'b100100000, ESC);
    checks++; if ({entry_active, run_en} !== 2'b11) begin errors++; $display("FAIL modes_esc_prio: got %b, required 11", {entry_active, run_en}); end
    press(ESC);
    checks++; if (entry_active !== 1'b0) begin errors++; $display("FAIL modes_esc_abort: got %0b, required 0", entry_active); end
  endtask

  task test_set_time;
    press(ESC);
    checks++;
    if ({entry_active, entry_idx, set_digits} !== {1'b1, 3'd0, 24'h0}) begin
      errors++; $display("FAIL time_open: active=%0b idx=%0d digits=%h, required 1 0 000000", entry_active, entry_idx, set_digits);
    end
    press_str("123456");
    checks++; if (entry_idx !== 3'd6) begin errors++; $display("FAIL time_idx: got %0d, required 6", entry_idx); end
    press("7");
    checks++; if (set_digits !== 24'h123456) begin errors++; $display("FAIL time_digits: got %h, required 123456", set_digits); end
    exp_q.push_back({1'b0, 24'h123456});
    press(CR);
    checks++; if (set_time_pulse !== 1'b1) begin errors++; $display("FAIL time_pulse: got %0b, required 1", set_time_pulse); end
    @(negedge clk);
    checks++; if (set_time_pulse !== 1'b0) begin errors++; $display("FAIL time_pulse_len: got %0b, required 0", set_time_pulse); end
    drain("time_drain");
    checks++; if ({entry_active, run_en} !== 2'b01) begin errors++; $display("FAIL time_close: got %b, required 01", {entry_active, run_en}); end
  endtask

  task test_set_alarm;
    press("@");
    press_str("24");
    checks++; if (entry_idx !== 3'd1) begin errors++; $display("FAIL alarm_reject_h1: idx=%0d, required 1", entry_idx); end
    press_str("35959");
    checks++; if (entry_idx !== 3'd6) begin errors++; $display("FAIL alarm_idx: got %0d, required 6", entry_idx); end
    press("9");
    exp_q.push_back({1'b1, 24'h235959});
    press(CR);
    drain("alarm_drain");
    @(negedge clk);
    checks++; if ({entry_active, set_digits} !== {1'b0, 24'h235959}) begin
      errors++; $display("FAIL alarm_close: active=%0b digits=%h, required 0 235959", entry_active, set_digits);
    end
  endtask

  task test_abort;
    logic a0;
    press(ESC);
    press_str("17");
    press(CR);
    checks++; if ({entry_active, entry_idx} !== {1'b1, 3'd2}) begin
      errors++; $display("FAIL abort_cr_early: active=%0b idx=%0d, required 1 2", entry_active, entry_idx);
    end
    press_str("70");
    checks++; if ({entry_idx, set_digits} !== {3'd3, 24'h170000}) begin
      errors++; $display("FAIL abort_m10: idx=%0d digits=%h, required 3 170000", entry_idx, set_digits);
    end
    press(ESC);
    checks++; if ({entry_active, set_digits} !== {1'b0, 24'h170000}) begin
      errors++; $display("FAIL abort_esc: active=%0b digits=%h, required 0 170000", entry_active, set_digits);
    end
    a0 = alarm_en;
    press("A");
    checks++; if (alarm_en !== ~a0) begin errors++; $display("FAIL abort_idle: alarm=%0b, required %0b", alarm_en, ~a0); end
  endtask

  task test_timeout;
    press("S");
    press(ESC);
    press("1");
    repeat (7) @(negedge clk);
    checks++; if (entry_active !== 1'b1) begin errors++; $display("FAIL timeout_early: got %0b, required 1", entry_active); end
    @(negedge clk);
    checks++; if (entry_active !== 1'b0) begin errors++; $display("FAIL timeout_abort: got %0b, required 0", entry_active); end
    press(CR);
    checks++; if ({run_en, entry_active, set_digits} !== {2'b00, 24'h100000}) begin
      errors++; $display("FAIL timeout_cr: run=%0b active=%0b digits=%h, required 0 0 100000", run_en, entry_active, set_digits);
    end
  endtask

  task test_reset_mid;
    press("S");
    press(ESC);
    press_str("1234");
    checks++; if (entry_idx !== 3'd4) begin errors++; $display("FAIL rstmid_idx: got %0d, required 4", entry_idx); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++;
    if ({run_en, alarm_en, disp_hold, led_sel, entry_active, entry_idx, set_digits, set_time_pulse, set_alarm_pulse} !== 35'b0) begin
      errors++; $display("FAIL rstmid_outputs: run=%0b alarm=%0b hold=%0b led=%0d active=%0b idx=%0d digits=%h, required all 0",
                         run_en, alarm_en, disp_hold, led_sel, entry_active, entry_idx, set_digits);
    end
    press(CR);
    repeat (3) @(negedge clk);
    checks++; if ({run_en, entry_active} !== 2'b00) begin errors++; $display("FAIL rstmid_cr: got %b, required 00", {run_en, entry_active}); end
  endtask

  task test_back_to_back;
    press(ESC);
    press_str("235959");
    exp_q.push_back({1'b0, 24'h235959});
    press(CR);
    press("@");
    press_str("000000");
    exp_q.push_back({1'b1, 24'h000000});
    press(CR);
    drain("b2b_drain");
  endtask

  initial begin
    test_reset;
    test_modes;
    test_set_time;
    test_set_alarm;
    test_abort;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    repeat (3) @(negedge clk);
    drain("final_drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
